lifo_mc: RTL and testbench

//  Multi-channel LIFO: CHANNELS independent stacks, each 2**AWIDTH words deep, sharing one memory.

---
 rtl/lifo_mc_pkg.sv | 17 +
 rtl/lifo_mc_ram.sv | 38 +++
 rtl/lifo_mc.sv | 141 ++++++++++++++
 tb/tb_lifo_mc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lifo_mc_pkg.sv
// Shared types for the multi-channel LIFO: per-channel operation decode and usedw_o packing.
// Pure declarations, no timing or flow control of its own.
package lifo_mc_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_PUSHPOP = 2'b11
  } lifo_op_t;

  // Base bit of channel ch inside the flattened usedw_o vector.
  function automatic int usedw_slice(input int ch, input int awidth);
    return ch * (awidth + 1);
  endfunction

endpackage

// File: rtl/lifo_mc_ram.sv
// Simple dual-port RAM, read-first, registered read; read data holds when no read is issued.
// Latency 1 on read; no backpressure, one write and one read per cycle.
module lifo_mc_ram #(
  parameter int DWIDTH = 16,
  parameter int ABITS  = 10
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              we_i,
  input  logic [ABITS-1:0]  waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ABITS-1:0]  raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [2**ABITS];
  logic [DWIDTH-1:0] rd_d;
  logic [DWIDTH-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Array is sampled before the edge, so a same-address write returns the old word.
  always_comb begin
    rd_d = rd_q;
    if (re_i) rd_d = mem_q[raddr_i];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rd_q <= '0;
    else           rd_q <= rd_d;
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/lifo_mc.sv
// CHANNELS independent stacks in one RAM; pop data, valid and channel tag arrive 1 cycle after rdreq_i.
// No backpressure: pushes to a full channel and pops from an empty one are dropped with ovf_o/udf_o pulses.
module lifo_mc
  import lifo_mc_pkg::*;
#(
  parameter  int DWIDTH       = 16,
  parameter  int AWIDTH       = 8,
  parameter  int CHANNELS     = 4,
  parameter  int ALMOST_FULL  = 2,
  parameter  int ALMOST_EMPTY = 2,
  localparam int CWIDTH       = $clog2(CHANNELS)
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic [DWIDTH-1:0]              data_i,
  input  logic                           wrreq_i,
  input  logic [CWIDTH-1:0]              wr_ch_i,
  input  logic                           rdreq_i,
  input  logic [CWIDTH-1:0]              rd_ch_i,
  input  logic                           flush_i,
  input  logic [CWIDTH-1:0]              flush_ch_i,
  output logic [DWIDTH-1:0]              q_o,
  output logic                           q_valid_o,
  output logic [CWIDTH-1:0]              q_ch_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0] usedw_o,
  output logic [CHANNELS-1:0]            empty_o,
  output logic [CHANNELS-1:0]            full_o,
  output logic [CHANNELS-1:0]            almost_full_o,
  output logic [CHANNELS-1:0]            almost_empty_o,
  output logic                           ovf_o,
  output logic                           udf_o
);

  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(2**AWIDTH);
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY);
  localparam logic [AWIDTH:0] ONE_W   = (AWIDTH+1)'(1);

  logic [AWIDTH:0]     usedw_q [CHANNELS];
  logic [AWIDTH:0]     usedw_d [CHANNELS];
  logic [CHANNELS-1:0] empty_q, empty_d, full_q, full_d;
  logic [CHANNELS-1:0] afull_q, afull_d, aempty_q, aempty_d;
  logic                q_valid_q, q_valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [CWIDTH-1:0]   q_ch_q, q_ch_d;

  logic              flush_rd, flush_wr, pop_ok, push_ok;
  logic [AWIDTH-1:0] rd_ptr, wr_ptr;
  lifo_op_t          op;

  always_comb begin
    flush_rd = flush_i && (flush_ch_i == rd_ch_i);
    flush_wr = flush_i && (flush_ch_i == wr_ch_i);
    pop_ok   = rdreq_i && !empty_q[rd_ch_i] && !flush_rd;
    push_ok  = wrreq_i && !full_q[wr_ch_i] && !flush_wr;
    udf_d    = rdreq_i && empty_q[rd_ch_i] && !flush_rd;
    ovf_d    = wrreq_i && full_q[wr_ch_i] && !flush_wr;
    rd_ptr   = usedw_q[rd_ch_i][AWIDTH-1:0] - AWIDTH'(1);
    // Pop-then-push on one channel reuses the slot just vacated by the pop.
    wr_ptr   = (pop_ok && (rd_ch_i == wr_ch_i)) ? rd_ptr : usedw_q[wr_ch_i][AWIDTH-1:0];
    q_valid_d = pop_ok;
    q_ch_d    = pop_ok ? rd_ch_i : q_ch_q;
  end

  always_comb begin
    op       = OP_NONE;
    empty_d  = '0;
    full_d   = '0;
    afull_d  = '0;
    aempty_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      usedw_d[c] = usedw_q[c];
      op = lifo_op_t'({pop_ok && (rd_ch_i == CWIDTH'(c)), push_ok && (wr_ch_i == CWIDTH'(c))});
      case (op)
        OP_PUSH:    usedw_d[c] = usedw_q[c] + ONE_W;
        OP_POP:     usedw_d[c] = usedw_q[c] - ONE_W;
        OP_PUSHPOP: usedw_d[c] = usedw_q[c];
        default:    usedw_d[c] = usedw_q[c];
      endcase
      if (flush_i && (flush_ch_i == CWIDTH'(c))) usedw_d[c] = '0;
      empty_d[c]  = (usedw_d[c] == '0);
      full_d[c]   = (usedw_d[c] == DEPTH_W);
      afull_d[c]  = (usedw_d[c] >= AF_W);
      aempty_d[c] = (usedw_d[c] <= AE_W);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      usedw_q   <= '{default: '0};
      empty_q   <= '1;
      full_q    <= '0;
      afull_q   <= '0;
      aempty_q  <= '1;
      q_valid_q <= 1'b0;
      q_ch_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      usedw_q   <= usedw_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      q_valid_q <= q_valid_d;
      q_ch_q    <= q_ch_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  lifo_mc_ram #(
    .DWIDTH (DWIDTH),
    .ABITS  (CWIDTH + AWIDTH)
  ) u_ram (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .we_i     (push_ok),
    .waddr_i  ({wr_ch_i, wr_ptr}),
    .wdata_i  (data_i),
    .re_i     (pop_ok),
    .raddr_i  ({rd_ch_i, rd_ptr}),
    .rdata_o  (q_o)
  );

  always_comb begin
    usedw_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      usedw_o[usedw_slice(c, AWIDTH) +: AWIDTH+1] = usedw_q[c];
    end
  end

  assign q_valid_o      = q_valid_q;
  assign q_ch_o         = q_ch_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign ovf_o          = ovf_q;
  assign udf_o          = udf_q;

endmodule

// File: tb/tb_lifo_mc.sv
// Bench for lifo_mc: directed scenarios plus random traffic, every cycle compared against queue-based stacks.
module tb_lifo_mc;

  localparam int DW = 16, AW = 3, CH = 4, CW = 2, AF = 6, AE = 2, DEPTH = 8;

  logic              clk_i = 1'b0;
  logic              arst_n_i;
  logic [DW-1:0]     data_i;
  logic              wrreq_i, rdreq_i, flush_i;
  logic [CW-1:0]     wr_ch_i, rd_ch_i, flush_ch_i;
  logic [DW-1:0]     q_o;
  logic              q_valid_o, ovf_o, udf_o;
  logic [CW-1:0]     q_ch_o;
  logic [CH*(AW+1)-1:0] usedw_o;
  logic [CH-1:0]     empty_o, full_o, almost_full_o, almost_empty_o;

  always #5 clk_i = ~clk_i;

  lifo_mc #(
    .DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .wrreq_i(wrreq_i), .wr_ch_i(wr_ch_i),
    .rdreq_i(rdreq_i), .rd_ch_i(rd_ch_i), .flush_i(flush_i), .flush_ch_i(flush_ch_i),
    .q_o(q_o), .q_valid_o(q_valid_o), .q_ch_o(q_ch_o), .usedw_o(usedw_o), .empty_o(empty_o),
    .full_o(full_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .ovf_o(ovf_o), .udf_o(udf_o)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] stk [CH][$];
  logic [DW-1:0] m_q;
  logic [CW-1:0] m_qch;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) stk[c].delete();
    m_q   = '0;
    m_qch = '0;
  endtask

  task automatic check_outputs(input bit e_qv, input bit e_ovf, input bit e_udf);
    logic [CH*(AW+1)-1:0] e_used;
    logic [CH-1:0] e_emp, e_full, e_af, e_ae;
    int u;
    e_used = '0; e_emp = '0; e_full = '0; e_af = '0; e_ae = '0;
    for (int c = 0; c < CH; c++) begin
      u = stk[c].size();
      e_used[c*(AW+1) +: AW+1] = 4'(u);
      e_emp[c]  = (u == 0);
      e_full[c] = (u == DEPTH);
      e_af[c]   = (u >= AF);
      e_ae[c]   = (u <= AE);
    end
    chk("q_valid", q_valid_o, e_qv);
    chk("q", q_o, m_q);
    chk("q_ch", q_ch_o, m_qch);
    chk("ovf", ovf_o, e_ovf);
    chk("udf", udf_o, e_udf);
    chk("usedw", usedw_o, e_used);
    chk("empty", empty_o, e_emp);
    chk("full", full_o, e_full);
    chk("almost_full", almost_full_o, e_af);
    chk("almost_empty", almost_empty_o, e_ae);
  endtask

  // One clock: drive, predict from the stack rules, then compare after the edge.
  task automatic step(input bit wr, input int wch, input logic [DW-1:0] din,
                      input bit rd, input int rch, input bit fl, input int fch);
    bit e_qv, e_ovf, e_udf;
    int pre_w;
    wrreq_i = wr; wr_ch_i = CW'(wch); data_i = din;
    rdreq_i = rd; rd_ch_i = CW'(rch);
    flush_i = fl; flush_ch_i = CW'(fch);
    e_qv = 0; e_ovf = 0; e_udf = 0;
    pre_w = stk[wch].size();
    if (rd && !(fl && fch == rch)) begin
      if (stk[rch].size() == 0) e_udf = 1;
      else begin
        m_q   = stk[rch].pop_back();
        m_qch = CW'(rch);
        e_qv  = 1;
      end
    end
    if (wr && !(fl && fch == wch)) begin
      if (pre_w == DEPTH) e_ovf = 1;
      else stk[wch].push_back(din);
    end
    if (fl) stk[fch].delete();
    @(posedge clk_i);
    #1;
    check_outputs(e_qv, e_ovf, e_udf);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    arst_n_i = 1'b0;
    data_i = '0; wrreq_i = 0; rdreq_i = 0; flush_i = 0;
    wr_ch_i = '0; rd_ch_i = '0; flush_ch_i = '0;
    model_reset();
    #12;
    check_outputs(0, 0, 0);
    @(negedge clk_i);
    arst_n_i = 1'b1;

    // 1: fill ch1 then overflow it
    for (int i = 0; i < 9; i++) begin
      step(1, 1, DW'(16'h0011 + i), 0, 0, 0, 0);
      if (i == 5) chk("t1_af_after6", almost_full_o[1], 1'b1);
    end
    chk("t1_usedw1", usedw_o[7:4], 4'd8);
    chk("t1_full", full_o, 4'b0010);
    chk("t1_ovf", ovf_o, 1'b1);
    idle();
    chk("t1_ovf_once", ovf_o, 1'b0);

    // 2: drain ch1 past empty
    for (int i = 0; i < 9; i++) begin
      step(0, 0, '0, 1, 1, 0, 0);
      if (i < 8) chk("t2_pop_val", q_o, DW'(16'h0018 - i));
    end
    chk("t2_udf", udf_o, 1'b1);
    chk("t2_qv", q_valid_o, 1'b0);
    chk("t2_hold", q_o, 16'h0011);

    // 3: push+pop on the same channel
    step(1, 2, 16'h000A, 0, 0, 0, 0);
    step(1, 2, 16'h000B, 0, 0, 0, 0);
    step(1, 2, 16'h000C, 1, 2, 0, 0);
    chk("t3_pp_q", q_o, 16'h000B);
    chk("t3_pp_used", usedw_o[11:8], 4'd2);
    step(0, 0, '0, 1, 2, 0, 0);
    chk("t3_pop_c", q_o, 16'h000C);
    for (int i = 0; i < 7; i++) step(1, 2, DW'(16'h0200 + i), 0, 0, 0, 0);
    step(1, 2, 16'h0BAD, 1, 2, 0, 0);
    chk("t3_full_pp_used", usedw_o[11:8], 4'd7);
    chk("t3_full_pp_ovf", ovf_o, 1'b1);
    step(0, 0, '0, 0, 0, 1, 2);

    // 4: push and pop on different channels
    step(1, 3, 16'h0031, 0, 0, 0, 0);
    step(1, 3, 16'h0032, 0, 0, 0, 0);
    step(1, 3, 16'h0033, 0, 0, 0, 0);
    step(1, 0, 16'h0055, 1, 3, 0, 0);
    chk("t4_q", q_o, 16'h0033);
    chk("t4_qch", q_ch_o, 2'd3);

    // 5: flush overrides a push to the same channel
    step(1, 0, 16'h0056, 0, 0, 0, 0);
    step(1, 0, 16'h0057, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 2, DW'(16'h0070 + i), 0, 0, 0, 0);
    step(1, 2, 16'h0077, 0, 0, 1, 2);
    chk("t5_used2", usedw_o[11:8], 4'd0);
    chk("t5_used0", usedw_o[3:0], 4'd3);
    step(0, 0, '0, 1, 2, 0, 0);
    chk("t5_udf", udf_o, 1'b1);

    // 6: async reset with a pop in flight
    wrreq_i = 0; flush_i = 0; rdreq_i = 1; rd_ch_i = 2'd0;
    #3;
    arst_n_i = 1'b0;
    #1;
    model_reset();
    check_outputs(0, 0, 0);
    @(posedge clk_i);
    #1;
    check_outputs(0, 0, 0);
    rdreq_i = 0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_outputs(0, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 6), int'($urandom_range(0, CH-1)), DW'($urandom),
           ($urandom_range(0, 9) < 5), int'($urandom_range(0, CH-1)),
           ($urandom_range(0, 29) == 0), int'($urandom_range(0, CH-1)));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
